// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: initiator side of the data-memory port.
// Converts byte/half/word loads and stores from the MEM stage into word
// accesses on a combinational-read memory. Sub-word stores are performed as
// read-modify-write; sub-word loads are lane-selected and extended.
// Optional feature macro: DM_RANGE_CHECK_EN (flags any address bit above AW-1).
module dm_access_ctrl #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_sign,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [31:0]   resp_rdata,
    output logic [AW-3:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic          dm_wr,
    input  logic [31:0]   dm_dout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Select the addressed lane of a memory word and sign/zero extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sign
    );
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = sign ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'h000000, shifted[7:0]};
            SZ_HALF: res = sign ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'h0000, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half of the old word with right-aligned store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [31:0] res;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    res = {old_word[31:8], wdata[7:0]};
                    2'd1:    res = {old_word[31:16], wdata[7:0], old_word[7:0]};
                    2'd2:    res = {old_word[31:24], wdata[7:0], old_word[15:0]};
                    2'd3:    res = {wdata[7:0], old_word[23:0]};
                    default: res = old_word;
                endcase
            end
            SZ_HALF: res = off[1] ? {wdata[15:0], old_word[15:0]}
                                  : {old_word[31:16], wdata[15:0]};
            default: res = wdata;
        endcase
        return res;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic          misalign_s;
    logic          range_err_s;
    logic          req_err_s;

`ifdef DM_RANGE_CHECK_EN
    // Any address bit beyond the memory window makes the request an error.
    assign range_err_s = |req_addr[31:AW];
`else
    logic addr_hi_unused_s;
    // Upper address bits alias into the memory window and are not examined.
    assign addr_hi_unused_s = ^req_addr[31:AW];
    assign range_err_s      = 1'b0;
`endif

    // Classify the incoming request as misaligned or reserved-size.
    always_comb begin
        misalign_s = 1'b0;
        case (req_size)
            SZ_BYTE: misalign_s = 1'b0;
            SZ_HALF: misalign_s = req_addr[0];
            SZ_WORD: misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
        req_err_s = misalign_s | range_err_s;
    end

    // Next-state, request capture and response formation.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        sign_d       = sign_q;
        addr_d       = addr_q;
        data_d       = data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    sign_d = req_sign;
                    addr_d = req_addr[AW-1:0];
                    data_d = req_wdata;
                    if (req_err_s) begin
                        // No memory access: report the error next cycle.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                resp_rdata_d = load_extract(dm_dout, addr_q[1:0], size_q, sign_q);
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RMW_RD: begin
                // data_q still holds the right-aligned store data here.
                data_d  = store_merge(dm_dout, data_q, addr_q[1:0], size_q);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign dm_addr    = addr_q[AW-1:2];
    assign dm_din     = data_q;
    // Reset gates the strobe immediately so an aborted write never lands.
    assign dm_wr      = rst_n & (state_q == ST_WRITE);

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed cases followed by random
// requests compared against a byte-array reference model.
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_wr;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023];
    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;

    logic [7:0]  ref_b [0:4095];
    logic [31:0] exp_last_rd;
    logic [31:0] last_rd;
    logic        last_err;
    int          n_tests;
    int          n_fail;

    dm_access_ctrl #(.AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge; bench preload via poke.
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_wr) mem[dm_addr] <= dm_din;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    task automatic poke(input int w, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = w[9:0]; poke_data = d;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // One request: model predicts outcome, DUT is driven and observed.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int nbytes, base, lat_exp, wr_exp, lat_obs, wr_cnt, wr_cyc;
        logic exp_err, err_obs;
        logic [31:0] v, rd_obs;
        nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_err = (size == 2'd3) || ((addr % nbytes) != 0);
`ifdef DM_RANGE_CHECK_EN
        if (addr >= 32'd4096) exp_err = 1'b1;
`endif
        base = int'(addr % 4096);
        if (!exp_err && !we) begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++) v = v | (32'(ref_b[base+i]) << (8*i));
            if (sign && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
            exp_last_rd = v;
        end
        if (!exp_err && we)
            for (int i = 0; i < nbytes; i++) ref_b[base+i] = wdata[8*i +: 8];
        lat_exp = exp_err ? 1 : (!we ? 2 : (nbytes == 4 ? 2 : 3));
        wr_exp  = (!exp_err && we) ? 1 : 0;

        @(negedge clk);
        chk({tag, "_ready_in"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat_obs = 0; wr_cnt = 0; wr_cyc = 0; err_obs = 1'b0; rd_obs = 32'h0;
        for (int c = 1; c <= 6 && lat_obs == 0; c++) begin
            @(negedge clk);
            if (dm_wr) begin wr_cnt++; wr_cyc = c; end
            if (resp_valid) begin lat_obs = c; err_obs = resp_err; rd_obs = resp_rdata; end
        end
        last_rd = rd_obs; last_err = err_obs;
        chk({tag, "_latency"}, 32'(lat_obs), 32'(lat_exp));
        chk({tag, "_err"}, 32'(err_obs), 32'(exp_err));
        chk({tag, "_wr_count"}, 32'(wr_cnt), 32'(wr_exp));
        if (wr_exp == 1) chk({tag, "_wr_cycle"}, 32'(wr_cyc), 32'(lat_exp - 1));
        chk({tag, "_rdata"}, rd_obs, exp_last_rd);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {30'd0, resp_valid, dm_wr}, 32'd0);
        chk({tag, "_ready_out"}, 32'(req_ready), 32'd1);
        chk({tag, "_mem"}, mem[base/4], ref_word(base/4));
    endtask

    // Reset asserted one cycle after acceptance: nothing may be written or reported.
    task automatic reset_mid(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag);
        int wr_cnt, rv_cnt;
        wr_cnt = 0; rv_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = size; req_sign = 1'b0;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0; rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (dm_wr) wr_cnt++;
            if (resp_valid) rv_cnt++;
        end
        exp_last_rd = 32'h0;
        chk({tag, "_no_write"}, 32'(wr_cnt), 32'd0);
        chk({tag, "_no_resp"}, 32'(rv_cnt), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rdata_clr"}, resp_rdata, 32'h0);
        chk({tag, "_mem"}, mem[(addr % 4096) / 4], ref_word(int'((addr % 4096) / 4)));
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        poke_en = 1'b0; poke_addr = 10'h0; poke_data = 32'h0;
        exp_last_rd = 32'h0; last_rd = 32'h0; last_err = 1'b0;

        for (int w = 0; w < 1024; w++) poke(w, $urandom);
        poke(1, 32'h8899_AABB);
        poke(2, 32'h0102_0304);

        @(negedge clk);
        chk("rst_outputs", {29'd0, resp_valid, resp_err, dm_wr}, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;

        run_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, "lb_5");
        chk("lb_5_const", last_rd, 32'hFFFF_FFAA);
        run_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, "lhu_6");
        chk("lhu_6_const", last_rd, 32'h0000_8899);
        run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw_4");
        chk("lw_4_const", last_rd, 32'h8899_AABB);
        run_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h11, "sb_5");
        chk("sb_5_const", mem[1], 32'h8899_11BB);
        run_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, "sw_8");
        chk("sw_8_const", mem[2], 32'hDEAD_BEEF);
        run_req(1'b0, 2'd1, 1'b1, 32'h3, 32'h0, "lh_3");
        chk("lh_3_const", 32'(last_err), 32'd1);
        run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, "rsvd");
        reset_mid(2'd1, 32'hA, 32'h5555, "sh_abort");
        chk("sh_abort_const", mem[2], 32'hDEAD_BEEF);
        reset_mid(2'd2, 32'h10, 32'hCAFE_F00D, "sw_abort");
        run_req(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, "lw_1004");
        run_req(1'b1, 2'd1, 1'b0, 32'h2, 32'hABCD, "sh_hi");
        run_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, "lh_hi");

        for (int k = 0; k < 80; k++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0)
                a = (sz == 2'd1) ? (a & 32'hFFFF_FFFE) : (sz == 2'd2) ? (a & 32'hFFFF_FFFC) : a;
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F000);
            run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
